mem_bus_arbiter: RTL and testbench
==================================

// Module: mem_bus_arbiter
// PURPOSE
//   Parametrised arbiter for the shared system bus/RAM. Replaces fixed time-slot muxing of SPI/CPU/video
//   with NUM_CLIENTS request/ack ports and fixed-priority or round-robin selection.
//   Each transaction is sequenced through SETUP, STROBE and HOLD phases that drive address, data, R/W and RAM strobes.
//   Sits between bus masters (SPI bridge, DMA, video fetch) and the top-level bus/RAM pins.
// PARAMETERS
//   NUM_CLIENTS    4   number of requesters, >=1; index 0 = highest fixed priority
//   ADDR_WIDTH     17  bus address width
//   DATA_WIDTH     8   bus data width
//   RR_MODE        1   1 = round-robin, 0 = fixed priority (lowest index wins)
//   SETUP_CYCLES   1   cycles address/data are stable before the strobe, >=1
//   STROBE_CYCLES  2   cycles ram_we_o is held for writes and the read-access window for reads, >=1
// PORTS
//   clk16_i      in   1               system clock
//   reset_i      in   1               async reset, active-high
//   req_i        in   NUM_CLIENTS     per-client request, held high until ack
//   rw_n_i       in   NUM_CLIENTS     per-client direction (1 = read, 0 = write)
//   addr_i       in   NUM_CLIENTS*AW  packed per-client address; client k at [k*AW +: AW]
//   wr_data_i    in   NUM_CLIENTS*DW  packed per-client write data
//   grant_o      out  NUM_CLIENTS     one-hot owner, high from SETUP through HOLD
//   ack_o        out  NUM_CLIENTS     one-cycle completion pulse, in HOLD
//   rd_data_o    out  DW              read data, valid while ack_o is high; otherwise holds last read
//   busy_o       out  1               high whenever state != IDLE
//   bus_addr_o   out  AW              latched address of the granted client
//   bus_addr_oe  out  1               address drive enable
//   bus_rw_no    out  1               latched direction
//   bus_data_i   in   DW              bus read data
//   bus_data_o   out  DW              latched write data
//   bus_data_oe  out  1               write-data drive enable
//   ram_oe_o     out  1               RAM output enable (reads)
//   ram_we_o     out  1               RAM write strobe (writes)
// BEHAVIOUR
//   - Reset (async): state=IDLE; all outputs 0; bus_rw_no=1; rr pointer=NUM_CLIENTS-1 (client 0 first).
//     Reset mid-transaction: outputs drop immediately, no ack_o is issued, and the transaction is discarded.
//   - FSM: IDLE -> SETUP (SETUP_CYCLES) -> STROBE (STROBE_CYCLES) -> HOLD (1) -> IDLE. Phase counter width = clog2(max+1).
//   - IDLE: if any req_i is set, pick a winner and latch its addr, rw_n and wr_data. Enter SETUP next cycle. Otherwise stay.
//   - Arbitration: RR_MODE=1 searches from (last_grant+1) mod NUM_CLIENTS upward with wrap and updates last_grant on grant.
//     RR_MODE=0 selects the lowest set index. The pointer updates only on grant.
//   - All outputs decode from registered state/latches only; no combinational path from req_i to any output.
//   - SETUP/STROBE/HOLD: bus_addr_oe=1, grant_o=one-hot winner. bus_addr_o, bus_rw_no and bus_data_o are constant for the whole transaction.
//   - Write: bus_data_oe=1 in SETUP..HOLD; ram_we_o=1 only in STROBE; ram_oe_o=0. HOLD provides data hold after WE falls.
//   - Read: ram_oe_o=1 in SETUP..HOLD; bus_data_oe=0; ram_we_o=0. bus_data_i is captured into rd_data_o on the edge leaving the last STROBE cycle.
//   - HOLD: ack_o[winner]=1 for exactly one cycle. Next cycle is IDLE, so there is at least one idle cycle between transactions.
//   - Handshake: the client keeps req_i high until it sees ack_o. A req_i still high in the cycle after ack_o is a NEW request.
//     Changes to addr/rw/data after grant are ignored (latched).
//   - Latency when idle: req_i sampled at edge 0 -> ack_o during cycle SETUP_CYCLES+STROBE_CYCLES+1 (4 with defaults). Throughput = 1 txn per S+T+2 cycles.
//   - Requests arriving during a transaction wait in their port; none are lost.
//   - NUM_CLIENTS=1: arbitration degenerates to req_i[0]; the pointer is unused.
// TESTING
//   1 Reset asserted in 2nd STROBE cycle of a write -> ram_we_o, bus_*_oe, grant_o=0 same cycle; no ack; after release, first grant goes to client 0.
//   2 Client 2 writes addr 17'h0E80F data 8'hA5 -> bus_addr_o=0E80F for cycles 1-4, ram_we_o high cycles 2-3 only, ack_o=4'b0100 at cycle 4.
//   3 Client 0 reads 17'h08000, bus_data_i=8'h3C -> rd_data_o=8'h3C with ack_o[0] at cycle 4; ram_we_o and bus_data_oe never high.
//   4 RR_MODE=1, all 4 clients re-requesting continuously -> grant order 0,1,2,3,0. RR_MODE=0 -> client 0 every time; client 3 never granted.
//   5 Client 1 raises req mid-transaction of client 3 -> client 3 acked first, one IDLE cycle, then grant_o=4'b0010; drive enables never overlap.
//   6 NUM_CLIENTS=1, SETUP_CYCLES=1, STROBE_CYCLES=1 -> write acked at cycle 3; back-to-back requests spaced 4 cycles apart.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// Shared bus/RAM arbiter: selects one of NUM_CLIENTS requesters (round-robin or fixed priority)
// and sequences the access through SETUP, STROBE and HOLD phases on the bus and RAM strobes.
module mem_bus_arbiter #(
    parameter int NUM_CLIENTS   = 4,
    parameter int ADDR_WIDTH    = 17,
    parameter int DATA_WIDTH    = 8,
    parameter int RR_MODE       = 1,
    parameter int SETUP_CYCLES  = 1,
    parameter int STROBE_CYCLES = 2
) (
    input  logic                              clk16_i,
    input  logic                              reset_i,
    input  logic [NUM_CLIENTS-1:0]            req_i,
    input  logic [NUM_CLIENTS-1:0]            rw_n_i,
    input  logic [NUM_CLIENTS*ADDR_WIDTH-1:0] addr_i,
    input  logic [NUM_CLIENTS*DATA_WIDTH-1:0] wr_data_i,
    output logic [NUM_CLIENTS-1:0]            grant_o,
    output logic [NUM_CLIENTS-1:0]            ack_o,
    output logic [DATA_WIDTH-1:0]             rd_data_o,
    output logic                              busy_o,
    output logic [ADDR_WIDTH-1:0]             bus_addr_o,
    output logic                              bus_addr_oe,
    output logic                              bus_rw_no,
    input  logic [DATA_WIDTH-1:0]             bus_data_i,
    output logic [DATA_WIDTH-1:0]             bus_data_o,
    output logic                              bus_data_oe,
    output logic                              ram_oe_o,
    output logic                              ram_we_o
);
    localparam int PTR_W   = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;
    localparam int MAX_CYC = (SETUP_CYCLES > STROBE_CYCLES) ? SETUP_CYCLES : STROBE_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);
    localparam logic [CNT_W-1:0] SETUP_LAST  = CNT_W'(SETUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] STROBE_LAST = CNT_W'(STROBE_CYCLES - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_STROBE, ST_HOLD} state_t;

    state_t                state_reg, state_next;
    logic [CNT_W-1:0]      cnt_reg, cnt_next;
    logic [PTR_W-1:0]      owner_reg, last_grant_reg;
    logic [PTR_W-1:0]      win_next, cand_idx;
    logic                  win_found;
    int                    cand;
    logic                  rw_n_reg, rw_sel;
    logic [ADDR_WIDTH-1:0] addr_reg, addr_sel;
    logic [DATA_WIDTH-1:0] wr_data_reg, wr_data_sel, rd_data_reg;

    // Winner search: round-robin starts just past the last grant, fixed priority starts at 0.
    always_comb begin
        win_next  = '0;
        win_found = 1'b0;
        cand      = 0;
        cand_idx  = '0;
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            if (RR_MODE != 0 && NUM_CLIENTS > 1) begin
                cand = int'(last_grant_reg) + 1 + i;
                if (cand >= NUM_CLIENTS) begin
                    cand = cand - NUM_CLIENTS;
                end
            end else begin
                cand = i;
            end
            cand_idx = PTR_W'(cand);
            if (!win_found && req_i[cand_idx]) begin
                win_found = 1'b1;
                win_next  = cand_idx;
            end
        end
    end

    always_comb begin
        addr_sel    = addr_i[ADDR_WIDTH-1:0];
        wr_data_sel = wr_data_i[DATA_WIDTH-1:0];
        rw_sel      = rw_n_i[0];
        for (int i = 1; i < NUM_CLIENTS; i++) begin
            if (win_next == PTR_W'(i)) begin
                addr_sel    = addr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
                wr_data_sel = wr_data_i[i*DATA_WIDTH +: DATA_WIDTH];
                rw_sel      = rw_n_i[i];
            end
        end
    end

    always_ff @(posedge clk16_i or posedge reset_i) begin
        if (reset_i) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            ST_IDLE: begin
                cnt_next = '0;
                if (win_found) begin
                    state_next = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (cnt_reg == SETUP_LAST) begin
                    state_next = ST_STROBE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            ST_STROBE: begin
                if (cnt_reg == STROBE_LAST) begin
                    state_next = ST_HOLD;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            default: begin
                state_next = ST_IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // Request fields are captured once at grant so clients may change them afterwards.
    always_ff @(posedge clk16_i or posedge reset_i) begin
        if (reset_i) begin
            owner_reg      <= '0;
            last_grant_reg <= PTR_W'(NUM_CLIENTS - 1);
            rw_n_reg       <= 1'b1;
            addr_reg       <= '0;
            wr_data_reg    <= '0;
            rd_data_reg    <= '0;
        end else begin
            if (state_reg == ST_IDLE && win_found) begin
                owner_reg      <= win_next;
                last_grant_reg <= win_next;
                rw_n_reg       <= rw_sel;
                addr_reg       <= addr_sel;
                wr_data_reg    <= wr_data_sel;
            end
            if (state_reg == ST_STROBE && cnt_reg == STROBE_LAST && rw_n_reg) begin
                rd_data_reg <= bus_data_i;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_CLIENTS; gi++) begin : g_client
            assign grant_o[gi] = (state_reg != ST_IDLE) && (owner_reg == PTR_W'(gi));
            assign ack_o[gi]   = (state_reg == ST_HOLD) && (owner_reg == PTR_W'(gi));
        end
    endgenerate

    always_comb begin
        busy_o      = (state_reg != ST_IDLE);
        bus_addr_oe = busy_o;
        bus_data_oe = busy_o && !rw_n_reg;
        ram_oe_o    = busy_o && rw_n_reg;
        ram_we_o    = (state_reg == ST_STROBE) && !rw_n_reg;
        bus_addr_o  = addr_reg;
        bus_rw_no   = rw_n_reg;
        bus_data_o  = wr_data_reg;
        rd_data_o   = rd_data_reg;
    end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Randomised bench for mem_bus_arbiter against a transaction-level model, plus a single-client
// short-timing instance and a fixed-priority instance driven with permanent requests.
module tb_mem_bus_arbiter;
    localparam int N = 4, AW = 17, DW = 8, S = 1, T = 2;
    localparam int HOLD_T = S + T + 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // main instance (round-robin, default timing)
    logic [N-1:0] req, rw_n, grant, ack;
    logic [N*AW-1:0] addr;
    logic [N*DW-1:0] wdata;
    logic [DW-1:0] rd_data, bus_data_in, bus_data_out;
    logic [AW-1:0] bus_addr;
    logic busy, bus_addr_oe, bus_rw_n, bus_data_oe, ram_oe, ram_we;

    mem_bus_arbiter #(.NUM_CLIENTS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RR_MODE(1),
                      .SETUP_CYCLES(S), .STROBE_CYCLES(T)) dut (
        .clk16_i(clk), .reset_i(rst), .req_i(req), .rw_n_i(rw_n), .addr_i(addr),
        .wr_data_i(wdata), .grant_o(grant), .ack_o(ack), .rd_data_o(rd_data), .busy_o(busy),
        .bus_addr_o(bus_addr), .bus_addr_oe(bus_addr_oe), .bus_rw_no(bus_rw_n),
        .bus_data_i(bus_data_in), .bus_data_o(bus_data_out), .bus_data_oe(bus_data_oe),
        .ram_oe_o(ram_oe), .ram_we_o(ram_we));

    // single client, one setup and one strobe cycle, writes only
    logic req1, rw1, grant1, ack1, busy1, bus_addr_oe1, bus_rw_n1, bus_data_oe1, ram_oe1, ram_we1;
    logic [AW-1:0] addr1, bus_addr1;
    logic [DW-1:0] wdata1, rd_data1, bus_data_in1, bus_data_out1;

    mem_bus_arbiter #(.NUM_CLIENTS(1), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RR_MODE(1),
                      .SETUP_CYCLES(1), .STROBE_CYCLES(1)) dut1 (
        .clk16_i(clk), .reset_i(rst), .req_i(req1), .rw_n_i(rw1), .addr_i(addr1),
        .wr_data_i(wdata1), .grant_o(grant1), .ack_o(ack1), .rd_data_o(rd_data1), .busy_o(busy1),
        .bus_addr_o(bus_addr1), .bus_addr_oe(bus_addr_oe1), .bus_rw_no(bus_rw_n1),
        .bus_data_i(bus_data_in1), .bus_data_o(bus_data_out1), .bus_data_oe(bus_data_oe1),
        .ram_oe_o(ram_oe1), .ram_we_o(ram_we1));

    // fixed priority, all clients reading continuously
    logic [N-1:0] fp_req, fp_rw_n, fp_grant, fp_ack;
    logic [N*AW-1:0] fp_addr;
    logic [N*DW-1:0] fp_wdata;
    logic [DW-1:0] fp_rd_data, fp_bus_data_in, fp_bus_data_out;
    logic [AW-1:0] fp_bus_addr;
    logic fp_busy, fp_bus_addr_oe, fp_bus_rw_n, fp_bus_data_oe, fp_ram_oe, fp_ram_we;

    mem_bus_arbiter #(.NUM_CLIENTS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RR_MODE(0),
                      .SETUP_CYCLES(S), .STROBE_CYCLES(T)) dut_fp (
        .clk16_i(clk), .reset_i(rst), .req_i(fp_req), .rw_n_i(fp_rw_n), .addr_i(fp_addr),
        .wr_data_i(fp_wdata), .grant_o(fp_grant), .ack_o(fp_ack), .rd_data_o(fp_rd_data),
        .busy_o(fp_busy), .bus_addr_o(fp_bus_addr), .bus_addr_oe(fp_bus_addr_oe),
        .bus_rw_no(fp_bus_rw_n), .bus_data_i(fp_bus_data_in), .bus_data_o(fp_bus_data_out),
        .bus_data_oe(fp_bus_data_oe), .ram_oe_o(fp_ram_oe), .ram_we_o(fp_ram_we));

    // reference model: m_t is the position inside a transaction (0 = idle, 1.. = cycles since grant)
    int m_t, m_owner, m_last, m1_t, mf_t;
    logic m_rw;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata, m_rd, mf_rd;
    int cyc, mode, n_checks, n_fail;
    bit hold_bus_data;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: got %0h, want %0h", tag, cyc, got, exp);
        end
    endtask

    function automatic int pick_rr(input logic [N-1:0] r, input int last);
        for (int d = 1; d <= N; d++) begin
            if (r[(last + d) % N]) return (last + d) % N;
        end
        return 0;
    endfunction

    task automatic model_reset();
        m_t = 0; m_owner = 0; m_last = N - 1;
        m_rw = 1'b1; m_addr = '0; m_wdata = '0; m_rd = '0;
        m1_t = 0; mf_t = 0; mf_rd = '0;
    endtask

    task automatic new_request(input int k);
        req[k] = 1'b1;
        rw_n[k] = 1'($urandom);
        addr[k*AW +: AW] = AW'($urandom);
        wdata[k*DW +: DW] = DW'($urandom);
    endtask

    task automatic drive_clients();
        for (int k = 0; k < N; k++) begin
            if (m_t == HOLD_T && m_owner == k) begin
                req[k] = 1'b0;
                if (mode == 2 || (mode == 1 && $urandom_range(0, 1) == 1)) new_request(k);
            end else if (mode == 1) begin
                if (!req[k] && $urandom_range(0, 3) == 0) new_request(k);
                else if (m_t != 0 && m_owner == k) begin
                    // owner scribbles over its fields; the transaction must not notice
                    rw_n[k] = 1'($urandom);
                    addr[k*AW +: AW] = AW'($urandom);
                    wdata[k*DW +: DW] = DW'($urandom);
                end
            end
        end
        if (!hold_bus_data) bus_data_in = DW'($urandom);
    endtask

    task automatic advance_model();
        if (rst) begin
            model_reset();
            return;
        end
        if (m_t == 0) begin
            if (req != '0) begin
                m_owner = pick_rr(req, m_last);
                m_last = m_owner;
                m_rw = rw_n[m_owner];
                m_addr = addr[m_owner*AW +: AW];
                m_wdata = wdata[m_owner*DW +: DW];
                m_t = 1;
            end
        end else begin
            if (m_t == S + T && m_rw) m_rd = bus_data_in;
            m_t = (m_t == HOLD_T) ? 0 : m_t + 1;
        end
        if (m1_t == 0) m1_t = req1 ? 1 : 0;
        else m1_t = (m1_t == 3) ? 0 : m1_t + 1;
        if (mf_t == 0) mf_t = (fp_req != '0) ? 1 : 0;
        else begin
            if (mf_t == S + T) mf_rd = fp_bus_data_in;
            mf_t = (mf_t == HOLD_T) ? 0 : mf_t + 1;
        end
    endtask

    task automatic compare_outputs();
        logic act, strobe, hold, act1, actf;
        logic [N-1:0] g_exp, gf_exp;
        act = (m_t != 0);
        strobe = (m_t > S) && (m_t <= S + T);
        hold = (m_t == HOLD_T);
        g_exp = '0;
        if (act) g_exp[m_owner] = 1'b1;
        check_eq("grant", grant, g_exp);
        check_eq("ack", ack, hold ? g_exp : '0);
        check_eq("busy", busy, act);
        check_eq("bus_addr_oe", bus_addr_oe, act);
        check_eq("bus_data_oe", bus_data_oe, act && !m_rw);
        check_eq("ram_oe", ram_oe, act && m_rw);
        check_eq("ram_we", ram_we, strobe && !m_rw);
        check_eq("bus_addr", bus_addr, m_addr);
        check_eq("bus_rw_n", bus_rw_n, m_rw);
        check_eq("bus_data_out", bus_data_out, m_wdata);
        check_eq("rd_data", rd_data, m_rd);
        act1 = (m1_t != 0);
        check_eq("n1_grant", grant1, act1);
        check_eq("n1_ack", ack1, m1_t == 3);
        check_eq("n1_ram_we", ram_we1, m1_t == 2);
        check_eq("n1_busy", busy1, act1);
        check_eq("n1_oe", {bus_addr_oe1, bus_data_oe1, ram_oe1}, {act1, act1, 1'b0});
        if (act1) check_eq("n1_bus", {bus_addr1, bus_data_out1, bus_rw_n1}, {addr1, wdata1, 1'b0});
        check_eq("n1_rd_data", rd_data1, 8'h00);
        actf = (mf_t != 0);
        gf_exp = actf ? 4'b0001 : 4'b0000;
        check_eq("fp_grant", fp_grant, gf_exp);
        check_eq("fp_ack", fp_ack, (mf_t == HOLD_T) ? 4'b0001 : 4'b0000);
        check_eq("fp_strobes", {fp_busy, fp_bus_addr_oe, fp_bus_data_oe, fp_ram_oe, fp_ram_we},
                 {actf, actf, 1'b0, actf, 1'b0});
        if (actf) check_eq("fp_bus", {fp_bus_addr, fp_bus_data_out, fp_bus_rw_n},
                           {fp_addr[AW-1:0], fp_wdata[DW-1:0], 1'b1});
        check_eq("fp_rd_data", fp_rd_data, mf_rd);
    endtask

    task automatic run_cycle();
        drive_clients();
        advance_model();
        @(negedge clk);
        cyc++;
        compare_outputs();
    endtask

    logic [N-1:0] order_exp [5];

    initial begin
        n_checks = 0; n_fail = 0; cyc = 0; mode = 0; hold_bus_data = 1'b0;
        rst = 1'b1;
        req = '0; rw_n = '0; addr = '0; wdata = '0; bus_data_in = '0;
        req1 = 1'b0; rw1 = 1'b0; addr1 = 17'h01234; wdata1 = 8'h5A; bus_data_in1 = 8'hEE;
        fp_req = '0; fp_rw_n = '1; fp_addr = {N{17'h0ABCD}}; fp_wdata = {N{8'h11}};
        fp_bus_data_in = 8'h77;
        model_reset();
        repeat (2) run_cycle();
        rst = 1'b0;
        run_cycle();

        // reset during the second strobe cycle of a write
        req[3] = 1'b1; rw_n[3] = 1'b0; addr[3*AW +: AW] = 17'h1F00F; wdata[3*DW +: DW] = 8'hC3;
        req1 = 1'b1; fp_req = '1;
        for (int i = 0; i < 10 && m_t != S + T; i++) run_cycle();
        check_eq("pre_reset_we", ram_we, 1'b1);
        rst = 1'b1;
        #1;
        check_eq("rst_ram_we", ram_we, 1'b0);
        check_eq("rst_oes", {bus_addr_oe, bus_data_oe, ram_oe}, 3'b000);
        check_eq("rst_grant", grant, 4'b0000);
        check_eq("rst_ack", ack, 4'b0000);
        for (int k = 0; k < 3; k++) new_request(k);
        mode = 2;
        repeat (2) run_cycle();
        rst = 1'b0;

        // continuous requests from everyone: rotation starting at client 0
        order_exp[0] = 4'b0001; order_exp[1] = 4'b0010; order_exp[2] = 4'b0100;
        order_exp[3] = 4'b1000; order_exp[4] = 4'b0001;
        begin
            int got_n;
            got_n = 0;
            for (int i = 0; i < 40 && got_n < 5; i++) begin
                run_cycle();
                if (m_t == 1) begin
                    check_eq($sformatf("rr_order%0d", got_n), grant, order_exp[got_n]);
                    got_n++;
                end
            end
        end
        mode = 0;
        for (int i = 0; i < 40 && (m_t != 0 || req != '0); i++) run_cycle();

        // client 2 write
        req[2] = 1'b1; rw_n[2] = 1'b0; addr[2*AW +: AW] = 17'h0E80F; wdata[2*DW +: DW] = 8'hA5;
        for (int k = 1; k <= 5; k++) begin
            run_cycle();
            if (k <= 4) check_eq($sformatf("wr_addr_c%0d", k), bus_addr, 17'h0E80F);
            check_eq($sformatf("wr_we_c%0d", k), ram_we, (k == 2 || k == 3));
            check_eq($sformatf("wr_ack_c%0d", k), ack, (k == 4) ? 4'b0100 : 4'b0000);
        end

        // client 0 read
        hold_bus_data = 1'b1; bus_data_in = 8'h3C;
        req[0] = 1'b1; rw_n[0] = 1'b1; addr[AW-1:0] = 17'h08000;
        for (int k = 1; k <= 5; k++) begin
            run_cycle();
            check_eq($sformatf("rd_no_write_c%0d", k), {ram_we, bus_data_oe}, 2'b00);
            if (k == 4) begin
                check_eq("rd_ack", ack, 4'b0001);
                check_eq("rd_data_at_ack", rd_data, 8'h3C);
            end
        end
        hold_bus_data = 1'b0;

        // client 1 arrives while client 3 owns the bus
        req[3] = 1'b1; rw_n[3] = 1'b0; addr[3*AW +: AW] = 17'h10003; wdata[3*DW +: DW] = 8'h33;
        for (int k = 1; k <= 6; k++) begin
            run_cycle();
            if (k == 2) begin
                req[1] = 1'b1; rw_n[1] = 1'b1; addr[AW +: AW] = 17'h00101;
            end
            if (k == 4) check_eq("late_ack3", ack, 4'b1000);
            if (k == 5) check_eq("late_idle_gap", {busy, grant}, 5'b00000);
            if (k == 6) check_eq("late_grant1", grant, 4'b0010);
        end
        for (int i = 0; i < 40 && (m_t != 0 || req != '0); i++) run_cycle();

        // randomised traffic
        mode = 1;
        repeat (2500) run_cycle();
        mode = 0;
        for (int i = 0; i < 60 && (m_t != 0 || req != '0); i++) run_cycle();
        check_eq("drained", {busy, req}, 5'b00000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
